// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_forward_unit
// Description : Multi-lane operand/flag forwarding selects and load-use stall
//               sequencer for a superscalar in-order pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_forward_unit #(
    parameter  int LANES    = 2,
    parameter  int AW       = 3,
    parameter  int LOAD_LAT = 1,
    localparam int SW       = $clog2(2*LANES+1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [LANES*2*AW-1:0]   id_src_i,
    input  logic [LANES*2*AW-1:0]   ex_src_i,
    input  logic [LANES-1:0]        ex_wr_i,
    input  logic [LANES-1:0]        ex_load_i,
    input  logic [LANES*AW-1:0]     ex_rd_i,
    input  logic [LANES-1:0]        mem_wr_i,
    input  logic [LANES*AW-1:0]     mem_rd_i,
    input  logic [LANES-1:0]        wb_wr_i,
    input  logic [LANES*AW-1:0]     wb_rd_i,
    input  logic [LANES-1:0]        mem_flag_wr_i,
    input  logic [LANES-1:0]        mem_flag_i,
    input  logic [LANES-1:0]        wb_flag_wr_i,
    input  logic [LANES-1:0]        wb_flag_i,
    output logic [LANES*2*SW-1:0]   fwd_sel_o,
    output logic                    stall_o,
    output logic                    flag_fwd_o,
    output logic                    flag_arch_o
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       flag_arch_q, flag_arch_d;
    logic       w_hit;

    // Later assignments override earlier ones: MEM/WB first, then EX/MEM,
    // each in ascending lane order, so the highest EX/MEM lane wins.
    for (genvar o = 0; o < 2*LANES; o++) begin : g_op
        logic [AW-1:0] w_src;
        logic [SW-1:0] w_sel;

        assign w_src = ex_src_i[o*AW +: AW];

        always_comb begin
            w_sel = '0;
            for (int l = 0; l < LANES; l++) begin
                if (wb_wr_i[l] && (wb_rd_i[l*AW +: AW] == w_src) && (w_src != '0))
                    w_sel = SW'(LANES + 1 + l);
            end
            for (int l = 0; l < LANES; l++) begin
                if (mem_wr_i[l] && (mem_rd_i[l*AW +: AW] == w_src) && (w_src != '0))
                    w_sel = SW'(l + 1);
            end
        end

        assign fwd_sel_o[o*SW +: SW] = w_sel;
    end

    always_comb begin
        flag_fwd_o  = flag_arch_q;
        flag_arch_d = flag_arch_q;
        for (int l = 0; l < LANES; l++) begin
            if (wb_flag_wr_i[l]) begin
                flag_fwd_o  = wb_flag_i[l];
                flag_arch_d = wb_flag_i[l];
            end
        end
        for (int l = 0; l < LANES; l++) begin
            if (mem_flag_wr_i[l])
                flag_fwd_o = mem_flag_i[l];
        end
    end

    always_comb begin
        w_hit = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            for (int j = 0; j < 2*LANES; j++) begin
                if (ex_load_i[k] && ex_wr_i[k] && (ex_rd_i[k*AW +: AW] != '0) &&
                    (ex_rd_i[k*AW +: AW] == id_src_i[j*AW +: AW]))
                    w_hit = 1'b1;
            end
        end
    end

    // The IDLE cycle that detects the hit is the first stall cycle; STALL
    // covers the remaining LOAD_LAT-1 cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_o = 1'b0;
        case (state_q)
            IDLE: begin
                stall_o = w_hit;
                if (w_hit && (LOAD_LAT > 1)) begin
                    state_d = STALL;
                    cnt_d   = 3'(LOAD_LAT - 1);
                end
            end
            STALL: begin
                stall_o = 1'b1;
                if (cnt_q == 3'd1) begin
                    state_d = IDLE;
                    cnt_d   = 3'd0;
                end else begin
                    cnt_d   = cnt_q - 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 3'd0;
            end
        endcase
        if (reset)
            stall_o = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            flag_arch_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            flag_arch_q <= flag_arch_d;
        end
    end

    assign flag_arch_o = flag_arch_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_forward_unit
// Description : Randomized and directed bench for hazard_forward_unit against
//               a priority-search / timestamp reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

    localparam int LANES    = 2;
    localparam int AW       = 3;
    localparam int LOAD_LAT = 3;
    localparam int SW       = $clog2(2*LANES+1);
    localparam int IDW      = LANES*2*AW;
    localparam int RDW      = LANES*AW;
    localparam int FSW      = LANES*2*SW;

    logic            clk = 1'b0;
    logic            reset;
    logic [IDW-1:0]  id_src, ex_src;
    logic [LANES-1:0] ex_wr, ex_load, mem_wr, wb_wr;
    logic [RDW-1:0]  ex_rd, mem_rd, wb_rd;
    logic [LANES-1:0] mem_flag_wr, mem_flag, wb_flag_wr, wb_flag;
    logic [FSW-1:0]  fwd_sel;
    logic            stall, flag_fwd, flag_arch;

    always #5 clk = ~clk;

    hazard_forward_unit #(
        .LANES    (LANES),
        .AW       (AW),
        .LOAD_LAT (LOAD_LAT)
    ) u_dut (
        .clk           (clk),
        .reset         (reset),
        .id_src_i      (id_src),
        .ex_src_i      (ex_src),
        .ex_wr_i       (ex_wr),
        .ex_load_i     (ex_load),
        .ex_rd_i       (ex_rd),
        .mem_wr_i      (mem_wr),
        .mem_rd_i      (mem_rd),
        .wb_wr_i       (wb_wr),
        .wb_rd_i       (wb_rd),
        .mem_flag_wr_i (mem_flag_wr),
        .mem_flag_i    (mem_flag),
        .wb_flag_wr_i  (wb_flag_wr),
        .wb_flag_i     (wb_flag),
        .fwd_sel_o     (fwd_sel),
        .stall_o       (stall),
        .flag_fwd_o    (flag_fwd),
        .flag_arch_o   (flag_arch)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    int   cyc         = 0;
    int   stall_until = 0;
    logic m_flag_arch = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic int exp_sel(input int op);
        logic [AW-1:0] a;
        a = ex_src[op*AW +: AW];
        if (a == '0) return 0;
        for (int l = LANES-1; l >= 0; l--)
            if (mem_wr[l] && mem_rd[l*AW +: AW] == a) return l + 1;
        for (int l = LANES-1; l >= 0; l--)
            if (wb_wr[l] && wb_rd[l*AW +: AW] == a) return LANES + 1 + l;
        return 0;
    endfunction

    function automatic logic model_hit();
        for (int k = 0; k < LANES; k++) begin
            if (!(ex_load[k] && ex_wr[k]) || ex_rd[k*AW +: AW] == '0) continue;
            for (int j = 0; j < 2*LANES; j++)
                if (id_src[j*AW +: AW] == ex_rd[k*AW +: AW]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic exp_flag_fwd();
        for (int l = LANES-1; l >= 0; l--) if (mem_flag_wr[l]) return mem_flag[l];
        for (int l = LANES-1; l >= 0; l--) if (wb_flag_wr[l]) return wb_flag[l];
        return m_flag_arch;
    endfunction

    task automatic clear_inputs();
        reset = 1'b0;
        id_src = '0; ex_src = '0; ex_wr = '0; ex_load = '0; ex_rd = '0;
        mem_wr = '0; mem_rd = '0; wb_wr = '0; wb_rd = '0;
        mem_flag_wr = '0; mem_flag = '0; wb_flag_wr = '0; wb_flag = '0;
    endtask

    // Called just after a falling edge with inputs applied; checks, then
    // advances the model across the next rising edge.
    task automatic run_cycle();
        logic hit;
        logic e_stall;
        #1;
        hit     = model_hit();
        e_stall = reset ? 1'b0 : ((cyc < stall_until) ? 1'b1 : hit);
        for (int o = 0; o < 2*LANES; o++)
            check_eq($sformatf("fwd_sel[%0d]", o), 32'(fwd_sel[o*SW +: SW]), 32'(exp_sel(o)));
        check_eq("stall", 32'(stall), 32'(e_stall));
        check_eq("flag_fwd", 32'(flag_fwd), 32'(exp_flag_fwd()));
        check_eq("flag_arch", 32'(flag_arch), 32'(m_flag_arch));
        @(posedge clk);
        if (reset) begin
            stall_until = 0;
            m_flag_arch = 1'b0;
        end else begin
            if (cyc >= stall_until && hit) stall_until = cyc + LOAD_LAT;
            for (int l = LANES-1; l >= 0; l--) begin
                if (wb_flag_wr[l]) begin
                    m_flag_arch = wb_flag[l];
                    break;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_load_use();
        clear_inputs();
        ex_load = 2'b01; ex_wr = 2'b01;
        ex_rd[2:0]   = 3'd5;
        id_src[11:9] = 3'd5;
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        run_cycle();

        // EX/MEM lane 1 beats EX/MEM lane 0 and MEM/WB lane 0
        clear_inputs();
        ex_src[2:0] = 3'd3;
        mem_wr = 2'b11; mem_rd = {3'd3, 3'd3};
        wb_wr  = 2'b01; wb_rd[2:0] = 3'd3;
        #1 check_eq("dir_fwd_pri", 32'(fwd_sel[SW-1:0]), 32'd2);
        run_cycle();

        // register 0 never forwards or triggers load-use
        clear_inputs();
        mem_wr = '1; wb_wr = '1; ex_wr = '1; ex_load = '1;
        #1 check_eq("dir_r0_stall", 32'(stall), 32'd0);
        for (int o = 0; o < 2*LANES; o++)
            check_eq("dir_r0_fwd", 32'(fwd_sel[o*SW +: SW]), 32'd0);
        run_cycle();

        // single hit -> exactly LOAD_LAT stall cycles
        apply_load_use();
        #1 check_eq("dir_stall_c0", 32'(stall), 32'd1);
        run_cycle();
        clear_inputs();
        for (int c = 1; c <= LOAD_LAT + 1; c++) begin
            #1 check_eq($sformatf("dir_stall_c%0d", c), 32'(stall), (c < LOAD_LAT) ? 32'd1 : 32'd0);
            run_cycle();
        end

        // reset in the second stall cycle aborts the stall
        apply_load_use();
        run_cycle();
        clear_inputs();
        reset = 1'b1;
        #1 check_eq("dir_rst_mid", 32'(stall), 32'd0);
        run_cycle();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1 check_eq("dir_rst_after", 32'(stall), 32'd0);
            run_cycle();
        end

        // flag architectural update and forwarding priority
        clear_inputs();
        wb_flag_wr = 2'b11; wb_flag = 2'b10;
        run_cycle();
        clear_inputs();
        mem_flag_wr = 2'b01; mem_flag = 2'b00;
        #1 check_eq("dir_flag_fwd", 32'(flag_fwd), 32'd0);
        check_eq("dir_flag_arch", 32'(flag_arch), 32'd1);
        run_cycle();

        for (int i = 0; i < 400; i++) begin
            reset       = ($urandom_range(0, 39) == 0);
            id_src      = IDW'($urandom);
            ex_src      = IDW'($urandom);
            ex_wr       = LANES'($urandom);
            ex_load     = LANES'($urandom) & LANES'($urandom) & LANES'($urandom);
            ex_rd       = RDW'($urandom);
            mem_wr      = LANES'($urandom);
            mem_rd      = RDW'($urandom);
            wb_wr       = LANES'($urandom);
            wb_rd       = RDW'($urandom);
            mem_flag_wr = LANES'($urandom);
            mem_flag    = LANES'($urandom);
            wb_flag_wr  = LANES'($urandom);
            wb_flag     = LANES'($urandom);
            run_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
